// File: rtl/fp_pkt_pkg.sv
// Shared types and constants for the fingerprint-module command packet path.
// Combinational only: no latency and no flow control of its own.
// Holds the FSM state enum, the frame header bytes and the sensor instruction codes.
package fp_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] HDR0    = 8'hEF;
    localparam logic [7:0] HDR1    = 8'h01;
    localparam logic [7:0] PID_CMD = 8'h01;

    localparam logic [7:0] GEN_IMG     = 8'h01;
    localparam logic [7:0] IMG2TZ      = 8'h02;
    localparam logic [7:0] SEARCH      = 8'h04;
    localparam logic [7:0] AUTO_SEARCH = 8'h11;

endpackage

// File: rtl/fp_period_timer.sv
// Free-running tick generator: one-cycle tick every TC+1 enabled cycles.
// tick is combinational from the count, so it is high during the last cycle of each period.
// No backpressure; clr (or en low) returns the count to zero.
module fp_period_timer #(
    parameter int unsigned TC = 49_999_999
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [31:0] cnt;

    assign tick = en && (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == TC) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fp_cmd_pkt_tx.sv
// Builds an EF01 sensor command frame and streams it to the UART one byte at a time.
// First tx_start two cycles after the trigger; each later byte one cycle after tx_done.
// Paced by tx_done; optional FP_TX_TIMEOUT_EN aborts with err when tx_done never arrives.
module fp_cmd_pkt_tx
    import fp_pkt_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned PERIOD_MS   = 1000,
    parameter int unsigned MAX_PAR     = 5,
    parameter logic [31:0] DEV_ADDR    = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 auto_en,
    input  logic [7:0]           cmd_code,
    input  logic [8*MAX_PAR-1:0] param,
    input  logic [2:0]           param_len,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 pkt_done,
    output logic                 err
);

    localparam int unsigned TIMER_TC = CLK_HZ / 1000 * PERIOD_MS - 1;

    state_t               state;
    logic                 pending;
    logic [4:0]           idx;
    logic [15:0]          csum;
    logic [7:0]           cmd_q;
    logic [8*MAX_PAR-1:0] param_q;
    logic [2:0]           plen_q;
    logic [2:0]           plen_sat;
    logic [4:0]           last_idx;
    logic [4:0]           nidx;
    logic [7:0]           nbyte;
    logic                 tick;
    logic                 trig;
`ifdef FP_TX_TIMEOUT_EN
    logic [31:0]          to_cnt;
`endif

    fp_period_timer #(
        .TC (TIMER_TC)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (auto_en),
        .clr  (!auto_en),
        .tick (tick)
    );

    assign trig     = start || tick;
    assign plen_sat = (param_len > 3'(MAX_PAR)) ? 3'(MAX_PAR) : param_len;
    assign last_idx = 5'd11 + {2'b00, plen_q};
    assign nidx     = idx + 5'd1;

    // Byte i of the frame from the latched command; checksum bytes read the running sum.
    function automatic logic [7:0] byte_at(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:    b = HDR0;
            5'd1:    b = HDR1;
            5'd2:    b = DEV_ADDR[31:24];
            5'd3:    b = DEV_ADDR[23:16];
            5'd4:    b = DEV_ADDR[15:8];
            5'd5:    b = DEV_ADDR[7:0];
            5'd6:    b = PID_CMD;
            5'd7:    b = 8'h00;
            5'd8:    b = {5'd0, plen_q} + 8'd3;
            5'd9:    b = cmd_q;
            default: begin
                if (i < last_idx - 5'd1) begin
                    b = param_q[8*(int'(i)-10) +: 8];
                end else if (i == last_idx - 5'd1) begin
                    b = csum[15:8];
                end else begin
                    b = csum[7:0];
                end
            end
        endcase
        return b;
    endfunction

    assign nbyte = byte_at(nidx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            err      <= 1'b0;
            pending  <= 1'b0;
            idx      <= '0;
            csum     <= '0;
            cmd_q    <= '0;
            param_q  <= '0;
            plen_q   <= '0;
`ifdef FP_TX_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            pkt_done <= 1'b0;
            err      <= 1'b0;
            if (tick && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    cmd_q    <= cmd_code;
                    param_q  <= param;
                    plen_q   <= plen_sat;
                    csum     <= '0;
                    idx      <= '0;
                    tx_data  <= HDR0;
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    state <= WAIT;
`ifdef FP_TX_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (tx_done) begin
                        if (idx == last_idx) begin
                            state    <= DONE;
                            pkt_done <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            idx      <= nidx;
                            tx_data  <= nbyte;
                            tx_start <= 1'b1;
                            state    <= SEND;
                            // Sum runs from PID through the last parameter byte.
                            if (nidx >= 5'd6 && nidx <= last_idx - 5'd2) begin
                                csum <= csum + {8'h00, nbyte};
                            end
                        end
                    end
`ifdef FP_TX_TIMEOUT_EN
                    else if (to_cnt == TIMEOUT_CYC - 1) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        pending <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                DONE: begin
                    // A tick seen while busy (or in this cycle) launches the next frame directly.
                    if (pending || tick) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
